// File: rtl/perf_monitor.sv
// Performance monitor beside the cpu core: counts cycles, retired instructions and generic
// events, then derives fixed-point CPI with a restoring divider and offers a registered readout.
module perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int N_EVT       = 4,
  parameter int STATE_W     = 3,
  parameter int FETCH_STATE = 0,
  parameter int FRAC_W      = 8,
  parameter int SATURATE    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic [STATE_W-1:0]           cpu_state,
  input  logic                         halted,
  input  logic [N_EVT-1:0]             evt,
  input  logic [$clog2(N_EVT+3)-1:0]   rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic                         running,
  output logic                         done,
  output logic [CNT_W+FRAC_W-1:0]      cpi,
  output logic [N_EVT+1:0]             ovf,
  output logic                         div_zero
);

  localparam int SEL_W  = $clog2(N_EVT+3);
  localparam int Q_W    = CNT_W + FRAC_W;
  localparam int STEP_W = $clog2(Q_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cycles;
  logic [CNT_W-1:0]   instrs;
  logic [CNT_W-1:0]   evt_cnt [N_EVT];

  // Divider: dq shifts dividend bits out the top and quotient bits in the bottom.
  logic [Q_W-1:0]     dq;
  logic [CNT_W-1:0]   rem;
  logic [STEP_W-1:0]  step;
  logic               div_init;

  logic               zero_cnt;
  logic               count_en;
  logic               is_fetch;
  logic [CNT_W:0]     cyc_bump;
  logic [CNT_W:0]     ins_bump;
  logic [CNT_W:0]     evt_bump [N_EVT];
  logic [CNT_W:0]     rem_sh;
  logic [CNT_W:0]     rem_sub;
  logic               q_bit;
  logic [CNT_W-1:0]   rem_nx;
  logic [Q_W-1:0]     dq_nx;
  logic [CNT_W-1:0]   rd_mux;

  // Returns {overflow, next value}; an all-ones counter either sticks or wraps.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, (SATURATE != 0) ? v : {CNT_W{1'b0}}};
    return {1'b0, v + 1'b1};
  endfunction

  always_comb begin
    zero_cnt = clear || (start && state != S_DIV);
    count_en = (state == S_RUN) && !start && (halted || !stop);
    is_fetch = (cpu_state == STATE_W'(FETCH_STATE));
    cyc_bump = bump(cycles);
    ins_bump = bump(instrs);
    for (int i = 0; i < N_EVT; i++) evt_bump[i] = bump(evt_cnt[i]);
  end

  // rem_sh < 2*divisor, so the sign of the difference alone decides the quotient bit.
  always_comb begin
    rem_sh  = {rem, dq[Q_W-1]};
    rem_sub = rem_sh - {1'b0, instrs};
    q_bit   = !rem_sub[CNT_W];
    rem_nx  = q_bit ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    dq_nx   = {dq[Q_W-2:0], q_bit};
  end

  always_comb begin
    // NOTE: every path of a combinational block must assign its outputs; defaulting first keeps a latch from being inferred.
    rd_mux = '0;
    if (rd_sel == SEL_W'(0)) rd_mux = cycles;
    if (rd_sel == SEL_W'(1)) rd_mux = instrs;
    for (int i = 0; i < N_EVT; i++)
      if (rd_sel == SEL_W'(i + 2)) rd_mux = evt_cnt[i];
    if (rd_sel == SEL_W'(N_EVT + 2)) rd_mux = cpi[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: evt_cnt is a handful of flops rather than a RAM, so resetting it in a loop is cheap and intended.
    if (!reset) begin
      cycles <= '0;
      instrs <= '0;
      ovf    <= '0;
      for (int i = 0; i < N_EVT; i++) evt_cnt[i] <= '0;
    end else if (zero_cnt) begin
      cycles <= '0;
      instrs <= '0;
      ovf    <= '0;
      for (int i = 0; i < N_EVT; i++) evt_cnt[i] <= '0;
    end else if (count_en) begin
      cycles <= cyc_bump[CNT_W-1:0];
      ovf[0] <= ovf[0] | cyc_bump[CNT_W];
      if (is_fetch) begin
        instrs <= ins_bump[CNT_W-1:0];
        ovf[1] <= ovf[1] | ins_bump[CNT_W];
      end
      for (int i = 0; i < N_EVT; i++) begin
        if (evt[i]) begin
          evt_cnt[i] <= evt_bump[i][CNT_W-1:0];
          ovf[2+i]   <= ovf[2+i] | evt_bump[i][CNT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, matching the hardware.
    if (!reset) begin
      state    <= S_IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      cpi      <= '0;
      div_zero <= 1'b0;
      dq       <= '0;
      rem      <= '0;
      step     <= '0;
      div_init <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      state    <= S_IDLE;
      running  <= 1'b0;
      done     <= 1'b0;
      cpi      <= '0;
      div_zero <= 1'b0;
      dq       <= '0;
      rem      <= '0;
      step     <= '0;
      div_init <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_data <= rd_mux;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (!start && (halted || stop)) begin
            state    <= S_DIV;
            running  <= 1'b0;
            div_init <= 1'b1;
          end
        end
        S_DIV: begin
          if (div_init) begin
            div_init <= 1'b0;
            if (instrs == '0) begin
              div_zero <= 1'b1;
              cpi      <= '1;
              state    <= S_DONE;
              done     <= 1'b1;
            end else begin
              dq   <= {cycles, {FRAC_W{1'b0}}};
              rem  <= '0;
              step <= '0;
            end
          end else begin
            dq   <= dq_nx;
            rem  <= rem_nx;
            step <= step + 1'b1;
            if (step == STEP_W'(Q_W - 1)) begin
              cpi   <= dq_nx;
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state    <= S_RUN;
            running  <= 1'b1;
            done     <= 1'b0;
            cpi      <= '0;
            div_zero <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: one default instance plus two 4-bit instances
// (saturating and wrapping) sharing the same stimulus.
module tb_perf_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        halted = 1'b0;
  logic [2:0]  cpu_state = 3'd1;
  logic [3:0]  evt = 4'h0;
  logic [2:0]  rd_sel = 3'd0;

  logic [31:0] rd_data;
  logic        running, done, div_zero;
  logic [39:0] cpi;
  logic [5:0]  ovf;

  logic [3:0]  rd_data_s, rd_data_w;
  logic        running_s, running_w, done_s, done_w, div_zero_s, div_zero_w;
  logic [11:0] cpi_s, cpi_w;
  logic [5:0]  ovf_s, ovf_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_monitor dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .cpu_state(cpu_state), .halted(halted), .evt(evt), .rd_sel(rd_sel),
    .rd_data(rd_data), .running(running), .done(done), .cpi(cpi), .ovf(ovf),
    .div_zero(div_zero)
  );

  perf_monitor #(.CNT_W(4), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .cpu_state(cpu_state), .halted(halted), .evt(evt), .rd_sel(rd_sel),
    .rd_data(rd_data_s), .running(running_s), .done(done_s), .cpi(cpi_s), .ovf(ovf_s),
    .div_zero(div_zero_s)
  );

  perf_monitor #(.CNT_W(4), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .cpu_state(cpu_state), .halted(halted), .evt(evt), .rd_sel(rd_sel),
    .rd_data(rd_data_w), .running(running_w), .done(done_w), .cpi(cpi_w), .ovf(ovf_w),
    .div_zero(div_zero_w)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] sel, output logic [31:0] d);
    rd_sel = sel;
    tick();
    d = rd_data;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({rd_data, cpi, ovf, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rd=%h cpi=%h ovf=%b dz=%b required all 0", rd_data, cpi, ovf, div_zero);
    end
    checks++;
    if ({running, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got running=%b done=%b required 0 0", running, done);
    end
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_state = 3'd0;
    evt = 4'hF;
    repeat (3) tick();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_running: got %b required 1", running);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got running=%b required 0", running);
    end
    tick();
    reset = 1'b1;
    cpu_state = 3'd1;
    evt = 4'h0;
    tick();
    rd(3'd0, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_cycles: got %0d required 0", d);
    end
    rd(3'd2, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_evt0: got %0d required 0", d);
    end
    checks++;
    if ({running, done, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: got running=%b done=%b ovf=%b required 0", running, done, ovf);
    end
  endtask

  task automatic test_cpi();
    logic [31:0] d;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cpu_state = (i == 1 || i == 3 || i == 5 || i == 7) ? 3'd0 : 3'd1;
      halted = (i == 9);
      tick();
    end
    halted = 1'b0;
    cpu_state = 3'd1;
    checks++;
    if ({running, done} !== 2'b00) begin
      errors++;
      $display("FAIL cpi_in_div: got running=%b done=%b required 0 0", running, done);
    end
    wait_done(n);
    checks++;
    if (n !== 41) begin
      errors++;
      $display("FAIL cpi_latency: got %0d cycles required 41", n);
    end
    checks++;
    if (cpi !== 40'h280) begin
      errors++;
      $display("FAIL cpi_value: got %h required 280", cpi);
    end
    checks++;
    if (div_zero !== 1'b0) begin
      errors++;
      $display("FAIL cpi_div_zero: got %b required 0", div_zero);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL cpi_cycles: got %0d required 10", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL cpi_instrs: got %0d required 4", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 32'h280) begin
      errors++;
      $display("FAIL cpi_readout: got %h required 280", d);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL dz_latency: got %0d cycles required 1", n);
    end
    checks++;
    if (div_zero !== 1'b1 || cpi !== 40'hFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL dz_result: got dz=%b cpi=%h required 1 ffffffffff", div_zero, cpi);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 32'd6) begin
      errors++;
      $display("FAIL dz_cycles: got %0d required 6", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(n);
    rd(3'd0, d);
    checks++;
    if (d !== 32'd20 || ovf !== 6'b0) begin
      errors++;
      $display("FAIL ovf_wide: got cycles=%0d ovf=%b required 20 000000", d, ovf);
    end
    checks++;
    if (rd_data_s !== 4'hF) begin
      errors++;
      $display("FAIL ovf_sat_cycles: got %h required f", rd_data_s);
    end
    checks++;
    if (ovf_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sat_flag: got %b required 1", ovf_s[0]);
    end
    checks++;
    if (rd_data_w !== 4'h4) begin
      errors++;
      $display("FAIL ovf_wrap_cycles: got %h required 4", rd_data_w);
    end
    checks++;
    if (ovf_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap_flag: got %b required 1", ovf_w[0]);
    end
  endtask

  task automatic test_events();
    logic [31:0] d;
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    evt = 4'b0101;
    repeat (5) tick();
    evt = 4'b0000;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(n);
    rd(3'd7, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL evt_out_of_range: got %0d required 0", d);
    end
    rd_sel = 3'd2;
    #1;
    checks++;
    if (rd_data !== 32'd0) begin
      errors++;
      $display("FAIL evt_latency_early: got %0d required 0", rd_data);
    end
    tick();
    checks++;
    if (rd_data !== 32'd5) begin
      errors++;
      $display("FAIL evt0: got %0d required 5", rd_data);
    end
    rd(3'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL evt1: got %0d required 0", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 32'd5) begin
      errors++;
      $display("FAIL evt2: got %0d required 5", d);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL evt3: got %0d required 0", d);
    end
  endtask

  task automatic test_clear_restart();
    logic [31:0] d;
    int n;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    checks++;
    if ({running, done, div_zero} !== 3'b000 || cpi !== 40'd0) begin
      errors++;
      $display("FAIL clr_state: got running=%b done=%b dz=%b cpi=%h required 0", running, done, div_zero, cpi);
    end
    cpu_state = 3'd0;
    rd(3'd2, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL clr_evt0: got %0d required 0", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL clr_idle_hold: got instrs=%0d required 0", d);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL rst_running: got %b required 1", running);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_state = (i % 2 == 0) ? 3'd0 : 3'd1;
      tick();
    end
    cpu_state = 3'd1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 41) begin
      errors++;
      $display("FAIL rst_latency: got %0d cycles required 41", n);
    end
    rd(3'd0, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL rst_cycles: got %0d required 4", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 32'd2) begin
      errors++;
      $display("FAIL rst_instrs: got %0d required 2", d);
    end
    checks++;
    if (cpi !== 40'h200) begin
      errors++;
      $display("FAIL rst_cpi: got %h required 200", cpi);
    end
  endtask

  initial begin
    test_reset();
    test_cpi();
    test_div_zero();
    test_overflow();
    test_events();
    test_clear_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
